lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store sequencing controller between the execute stage of the 3-stage RV32I pipeline and a handshaked data-memory bus.
- Accepts one memory operation at a time (opcode 0000011 / 0100011, funct3 size/sign), generates byte enables and aligned bus beats, and holds the pipeline stalled until the response returns.
- Returns sign/zero-extended load data for the writeback mux (wb_sel=10) and flags misaligned or bus-error accesses to the CSR/trap logic.

Parameters:
- TIMEOUT_CYCLES, 255, cycles waited for grant or response before error (used only with the optional feature).
- CNT_W, 8, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-low.
- mem_start  input  1  pulse or level: execute stage presents a memory op this cycle.
- is_store  input  1  1=store, 0=load.
- funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  32  effective address from ALU.
- wdata  input  32  store data (rs2).
- stall  output  1  freeze PC/pipeline registers.
- ld_data  output  32  extended load result, valid with done.
- done  output  1  one-cycle completion pulse.
- misalign  output  1  one-cycle pulse: misaligned address; no bus access made.
- bus_err_o  output  1  one-cycle pulse: bus error or timeout.
- bus_req  output  1  request valid.
- bus_we  output  1  write enable.
- bus_addr  output  32  address with [1:0] forced to 00.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-shifted store data.
- bus_gnt  input  1  request accepted this cycle.
- bus_rvalid  input  1  response valid (loads and stores).
- bus_rdata  input  32  read data.
- bus_err  input  1  error qualifier with bus_rvalid.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; ld_data 0; counter 0. A reset mid-transaction aborts it with no done pulse. The bus must tolerate an abandoned request.
- States: IDLE, REQ, RSP, FIN.
- IDLE:
  - If mem_start and the access is aligned, latch is_store/funct3/addr/wdata, go to REQ, and assert stall the same cycle (stall is combinationally high in IDLE when mem_start=1).
  - Alignment rule: H/HU need addr[0]=0; W needs addr[1:0]=00.
  - If misaligned: misalign=1 for that cycle, stay IDLE, no stall, no bus activity.
  - Invalid funct3 (011, 110, 111) is treated as misaligned.
- REQ:
  - bus_req=1; address, enables and data are held stable until bus_gnt.
  - On bus_gnt: go to RSP; bus_req drops the next cycle.
  - bus_gnt and bus_rvalid in the same cycle: go directly to FIN, capturing the data.
- RSP: wait for bus_rvalid.
  - On bus_rvalid with bus_err=0: capture and extend the data, go to FIN.
  - On bus_rvalid with bus_err=1: bus_err_o=1, go to FIN with done suppressed.
- FIN:
  - done=1 (unless errored); stall=0; return to IDLE.
  - A new mem_start in FIN is ignored. The pipeline advances that cycle, so back-to-back ops start 1 cycle later.
- stall is high in REQ, in RSP, and in IDLE when a valid start is presented. Minimum latency with gnt+rvalid in the same cycle: start→done in 2 cycles.
- Byte enables, with offset o = addr[1:0]:
  - B: 0001<<o.
  - H: 0011<<o.
  - W: 1111.
- Store data:
  - bus_wdata = wdata replicated per size (B: {4{wdata[7:0]}}; H: {2{wdata[15:0]}}).
- Load data: select lane by o, then extend.
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- ld_data holds its value until the next load completes. Stores do not update it.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ and on entry to RSP, and increments each cycle in REQ or RSP. Reaching TIMEOUT_CYCLES forces bus_err_o=1, drops bus_req, and goes to FIN without done.
- Undefined: no counter; the FSM waits indefinitely. TIMEOUT_CYCLES and CNT_W are unused.

Decomposition:
- Shared package lsu_pkg holds:
  - Typedef enum of states.
  - funct3 size constants (LS_B, LS_H, LS_W, LS_BU, LS_HU).
  - Opcode constants OPC_LOAD=0000011 and OPC_STORE=0100011, reused by the controller decoder.
- One sub-module, lsu_align: combinational byte-enable generation, store lane replication, and load lane select/extension. The FSM stays in lsu_ctrl.

Test Plan:
- LB at addr 0x103, bus_rdata 0x80FF_FF00, gnt and rvalid 1 cycle after request → bus_be 1000, bus_addr 0x100, ld_data 0xFFFF_FF80, done once, stall high exactly 2 cycles.
- SH wdata 0x1234_ABCD at addr 0x202 → bus_we=1, bus_be 1100, bus_wdata 0xABCD_ABCD; done on rvalid; ld_data unchanged.
- LW at addr 0x006 → misalign pulse the same cycle, bus_req never asserted, stall stays 0.
- LHU at 0x000; bus_gnt held low 5 cycles, rvalid with err=1 → bus_req stable all 5 cycles, bus_err_o pulse, no done.
- rst driven low while in RSP → next cycle IDLE, all outputs 0; a later rvalid is ignored.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never asserted → bus_err_o after 4 REQ cycles, FSM back in IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared states, access-size codes and opcodes for the load/store unit
//   IDLE/REQ/RSP/FIN  controller states
//   LS_*              funct3 access-size codes
//   OPC_*             RV32I load/store major opcodes
//   is_aligned()      legal funct3 and natural alignment check
package lsu_pkg;
   typedef enum logic [1:0] {IDLE, REQ, RSP, FIN} lsu_state_e;
   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   // unknown funct3 codes are reported as misaligned so they never reach the bus
   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
      return (f3 == LS_B || f3 == LS_BU) ? 1'b1 :
             (f3 == LS_H || f3 == LS_HU) ? !off[0] :
             (f3 == LS_W) ? (off == 2'b00) : 1'b0;
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane replication and load lane extraction
//   funct3      access size/sign of the latched op
//   off         byte offset addr[1:0]
//   wdata       raw store data (rs2)
//   rdata       raw bus read word
//   be          byte enables for the bus beat
//   wdata_lane  store data replicated across all lanes
//   ld_ext      selected lane, sign/zero-extended
module lsu_align import lsu_pkg::*; (
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] ld_ext
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = rdata[{off, 3'b000} +: 8];
   assign h = off[1] ? rdata[31:16] : rdata[15:0];
   assign be = (funct3[1:0] == 2'b00) ? 4'b0001 << off :
               (funct3[1:0] == 2'b01) ? 4'b0011 << off : 4'b1111;
   assign wdata_lane = (funct3[1:0] == 2'b00) ? {4{wdata[7:0]}} :
                       (funct3[1:0] == 2'b01) ? {2{wdata[15:0]}} : wdata;
   assign ld_ext = (funct3 == LS_B)  ? {{24{b[7]}}, b} :
                   (funct3 == LS_BU) ? {24'b0, b} :
                   (funct3 == LS_H)  ? {{16{h[15]}}, h} :
                   (funct3 == LS_HU) ? {16'b0, h} : rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between execute stage and handshaked data bus
//   clk, rst (sync, active-low)
//   mem_start/is_store/funct3/addr/wdata  op from execute stage
//   stall, ld_data, done, misalign, bus_err_o  results to pipeline and trap logic
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata  request channel
//   bus_gnt/bus_rvalid/bus_rdata/bus_err      bus handshake and response
//   LSU_TIMEOUT_EN: when defined, a wait of TIMEOUT_CYCLES in REQ or RSP ends the op as a bus error
module lsu_ctrl import lsu_pkg::*; #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] ld_data,
   output logic        done,
   output logic        misalign,
   output logic        bus_err_o,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err
);
   lsu_state_e  state;
   logic        st_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be;
   logic [31:0] wlane, ld_ext;
   logic        start_ok, rsp, tmo;
   lsu_align u_align (
      .funct3(f3_q), .off(addr_q[1:0]), .wdata(wdata_q), .rdata(bus_rdata),
      .be(be), .wdata_lane(wlane), .ld_ext(ld_ext)
   );
   assign start_ok  = rst && state == IDLE && mem_start && is_aligned(funct3, addr[1:0]);
   assign misalign  = rst && state == IDLE && mem_start && !is_aligned(funct3, addr[1:0]);
   assign stall     = state == REQ || state == RSP || start_ok;
   // a grant carrying its response in the same cycle skips RSP
   assign rsp       = (state == REQ && bus_gnt && bus_rvalid) || (state == RSP && bus_rvalid);
   assign bus_req   = state == REQ;
   assign bus_we    = bus_req && st_q;
   assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'b0;
   assign bus_be    = bus_req ? be : 4'b0;
   assign bus_wdata = bus_we ? wlane : 32'b0;
`ifdef LSU_TIMEOUT_EN
   logic [CNT_W-1:0] cnt;
   assign tmo = !rsp && !(state == REQ && bus_gnt) && (state == REQ || state == RSP) &&
                cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
   logic unused_cfg;
   assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
   assign tmo = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         st_q      <= 1'b0;
         f3_q      <= 3'b0;
         addr_q    <= 32'b0;
         wdata_q   <= 32'b0;
         ld_data   <= 32'b0;
         done      <= 1'b0;
         bus_err_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt       <= '0;
`endif
      end else begin
         if (start_ok) begin
            st_q    <= is_store;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         done      <= rsp && !bus_err;
         bus_err_o <= (rsp && bus_err) || tmo;
         if (rsp && !bus_err && !st_q) ld_data <= ld_ext;
         state <= start_ok ? REQ :
                  (rsp || tmo) ? FIN :
                  (state == REQ && bus_gnt) ? RSP :
                  (state == FIN) ? IDLE : state;
`ifdef LSU_TIMEOUT_EN
         // restarts on entry to REQ (from IDLE) and on entry to RSP (grant)
         cnt <= ((state == REQ && !bus_gnt) || state == RSP) ? cnt + 1'b1 : '0;
`endif
      end
   end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized and directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;
   import lsu_pkg::*;
`ifdef LSU_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int TO = 4;

   logic        clk, rst, mem_start, is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        stall, done, misalign, bus_err_o, bus_req, bus_we;
   logic [31:0] ld_data, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   logic        bus_gnt, bus_rvalid, bus_err;

   int n_vec = 0, n_fail = 0;
   logic [31:0] ld_model;
   int o_stall, o_done, o_err, o_mis, o_req, o_done_cyc;
   bit o_unstable, o_hang, o_we;
   logic [31:0] o_addr, o_wdata, o_ld;
   logic [3:0]  o_be;

   lsu_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .mem_start(mem_start), .is_store(is_store), .funct3(funct3),
      .addr(addr), .wdata(wdata), .stall(stall), .ld_data(ld_data), .done(done),
      .misalign(misalign), .bus_err_o(bus_err_o), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model: access size in bytes, legality, lanes and extension
   function automatic int m_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction
   function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
      return (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && (int'(a[1:0]) % m_size(f3) == 0);
   endfunction
   function automatic logic [3:0] m_be(input logic [2:0] f3, input int o);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (i >= o) && (i < o + m_size(f3));
      return r;
   endfunction
   function automatic logic [31:0] m_wlane(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % m_size(f3)) +: 8];
      return r;
   endfunction
   function automatic logic [31:0] m_ld(input logic [2:0] f3, input int o, input logic [31:0] rd);
      int sz;
      logic [31:0] v, mask;
      sz = m_size(f3);
      v = rd >> (8*o);
      if (sz < 4) begin
         mask = (32'd1 << (8*sz)) - 32'd1;
         v = v & mask;
         if (!f3[2] && v[8*sz-1]) v = v | ~mask;
      end
      return v;
   endfunction

   // drives one op and bus responses, records what the DUT did
   task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input bit er, input int gdly, input int rdly);
      int nreq, nrsp, tail;
      bit granted, fin;
      nreq = 0; nrsp = 0; tail = 0; granted = 0; fin = 0;
      o_stall = 0; o_done = 0; o_err = 0; o_mis = 0; o_done_cyc = -1; o_unstable = 0; o_hang = 1;
      o_we = 0; o_addr = 0; o_wdata = 0; o_be = 0; o_ld = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         mem_start = (c == 0); is_store = st; funct3 = f3; addr = a; wdata = wd;
         bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = rd;
         if (bus_req) begin
            if (nreq == 0) begin
               o_we = bus_we; o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata;
            end else if ({bus_we, bus_addr, bus_be, bus_wdata} !== {o_we, o_addr, o_be, o_wdata}) o_unstable = 1;
            if (nreq >= gdly) begin
               bus_gnt = 1; granted = 1;
               if (rdly == 0) begin bus_rvalid = 1; bus_err = er; end
            end
            nreq++;
         end else if (granted && !fin) begin
            nrsp++;
            if (nrsp == rdly) begin bus_rvalid = 1; bus_err = er; end
         end
         #1;
         if (stall) o_stall++;
         if (misalign) o_mis++;
         if (bus_err_o) o_err++;
         if (done) begin o_done++; o_done_cyc = c; o_ld = ld_data; end
         if (done || bus_err_o || misalign) fin = 1;
         if (fin) tail++;
         if (tail == 3) begin o_hang = 0; break; end
      end
      o_req = nreq;
      mem_start = 0; bus_gnt = 0; bus_rvalid = 0; bus_err = 0;
   endtask

   task automatic test_reset;
      rst = 0; mem_start = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
      repeat (3) @(negedge clk);
      #1;
      n_vec++; if ({stall, done, misalign, bus_err_o, bus_req, bus_we} !== 6'b0) begin n_fail++;
         $display("FAIL reset_ctl: got %b want 000000", {stall, done, misalign, bus_err_o, bus_req, bus_we}); end
      n_vec++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus_addr); end
      n_vec++; if (bus_be !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %b want 0000", bus_be); end
      n_vec++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus_wdata); end
      n_vec++; if (ld_data !== 32'h0) begin n_fail++; $display("FAIL reset_ld: got %h want 0", ld_data); end
      ld_model = 0;
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_lb;
      do_op(0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF00, 0, 0, 0);
      n_vec++; if (o_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b want 1000", o_be); end
      n_vec++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h want 00000100", o_addr); end
      n_vec++; if (o_ld !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_ld: got %h want ffffff80", o_ld); end
      n_vec++; if (o_done !== 1) begin n_fail++; $display("FAIL lb_done: got %0d want 1", o_done); end
      n_vec++; if (o_stall !== 2) begin n_fail++; $display("FAIL lb_stall: got %0d want 2", o_stall); end
      n_vec++; if (o_done_cyc !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", o_done_cyc); end
      ld_model = 32'hFFFF_FF80;
   endtask

   task automatic test_sh;
      do_op(1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 1);
      n_vec++; if ({o_we, o_be} !== 5'b1_1100) begin n_fail++; $display("FAIL sh_we_be: got %b want 11100", {o_we, o_be}); end
      n_vec++; if (o_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); end
      n_vec++; if (o_done !== 1) begin n_fail++; $display("FAIL sh_done: got %0d want 1", o_done); end
      n_vec++; if (ld_data !== ld_model) begin n_fail++; $display("FAIL sh_ld_kept: got %h want %h", ld_data, ld_model); end
   endtask

   task automatic test_misalign;
      do_op(0, 3'b010, 32'h006, 32'h0, 32'h0, 0, 0, 0);
      n_vec++; if (o_mis !== 1) begin n_fail++; $display("FAIL mis_pulse: got %0d want 1", o_mis); end
      n_vec++; if (o_req !== 0) begin n_fail++; $display("FAIL mis_req: got %0d want 0", o_req); end
      n_vec++; if (o_stall !== 0) begin n_fail++; $display("FAIL mis_stall: got %0d want 0", o_stall); end
      n_vec++; if (o_done !== 0) begin n_fail++; $display("FAIL mis_done: got %0d want 0", o_done); end
   endtask

   task automatic test_err_stall;
      int e_req;
      bit to;
      to = TMO_EN && (5 + 1 > TO);
      e_req = to ? TO : 6;
      do_op(0, 3'b101, 32'h000, 32'h0, 32'hFFFF_FFFF, 1, 5, 1);
      n_vec++; if (o_req !== e_req) begin n_fail++; $display("FAIL err_req_cycles: got %0d want %0d", o_req, e_req); end
      n_vec++; if (o_unstable !== 0) begin n_fail++; $display("FAIL err_req_stable: got %0d want 0", o_unstable); end
      n_vec++; if ({o_err, o_done} !== {32'd1, 32'd0}) begin n_fail++;
         $display("FAIL err_pulse: got err=%0d done=%0d want err=1 done=0", o_err, o_done); end
      n_vec++; if (o_stall !== (to ? 1 + TO : 8)) begin n_fail++;
         $display("FAIL err_stall: got %0d want %0d", o_stall, to ? 1 + TO : 8); end
      n_vec++; if (ld_data !== ld_model) begin n_fail++; $display("FAIL err_ld_kept: got %h want %h", ld_data, ld_model); end
   endtask

   task automatic test_back_to_back;
      logic [5:0] dn, st;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         mem_start = 1; is_store = 1; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
         bus_gnt = bus_req; bus_rvalid = bus_req; bus_err = 0;
         #1;
         dn[c] = done; st[c] = stall;
      end
      @(negedge clk);
      mem_start = 0; bus_gnt = 0; bus_rvalid = 0;
      n_vec++; if (dn !== 6'b100100) begin n_fail++; $display("FAIL b2b_done: got %b want 100100", dn); end
      n_vec++; if (st !== 6'b011011) begin n_fail++; $display("FAIL b2b_stall: got %b want 011011", st); end
      @(negedge clk);
   endtask

   task automatic test_random;
      bit st, er, al, to;
      logic [2:0] f3;
      logic [31:0] a, wd, rd;
      int g, r, e_mis, e_done, e_err, e_stall, e_req, e_cyc;
      for (int k = 0; k < 60; k++) begin
         st = 1'($urandom_range(1, 0)); er = ($urandom_range(7, 0) == 0);
         f3 = 3'($urandom_range(7, 0)); a = $urandom; wd = $urandom; rd = $urandom;
         if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
         g = $urandom_range(2, 0); r = $urandom_range(3, 0);
         al = m_aligned(f3, a);
         to = al && TMO_EN && (g + 1 > TO);
         e_mis = al ? 0 : 1;
         e_done = (al && !to && !er) ? 1 : 0;
         e_err = (al && (to || er)) ? 1 : 0;
         e_req = !al ? 0 : to ? TO : g + 1;
         e_stall = !al ? 0 : to ? 1 + TO : 2 + g + r;
         e_cyc = e_done ? 2 + g + r : -1;
         do_op(st, f3, a, wd, rd, er, g, r);
         if (e_done && !st) ld_model = m_ld(f3, int'(a[1:0]), rd);
         n_vec++;
         if ({o_mis, o_done, o_err, o_stall, o_req, o_done_cyc, 31'd0, o_hang} !==
             {e_mis, e_done, e_err, e_stall, e_req, e_cyc, 32'd0}) begin
            n_fail++;
            $display("FAIL rand_status[%0d] f3=%b a=%h: got mis=%0d done=%0d err=%0d stall=%0d req=%0d cyc=%0d hang=%0d want %0d %0d %0d %0d %0d %0d 0",
                     k, f3, a, o_mis, o_done, o_err, o_stall, o_req, o_done_cyc, o_hang, e_mis, e_done, e_err, e_stall, e_req, e_cyc);
         end
         if (al) begin
            n_vec++;
            if ({o_we, o_addr, o_be, (st ? o_wdata : 32'h0)} !== {st, a & 32'hFFFF_FFFC, m_be(f3, int'(a[1:0])), (st ? m_wlane(f3, wd) : 32'h0)}) begin
               n_fail++;
               $display("FAIL rand_bus[%0d]: got we=%0d addr=%h be=%b wdata=%h want we=%0d addr=%h be=%b wdata=%h",
                        k, o_we, o_addr, o_be, o_wdata, st, a & 32'hFFFF_FFFC, m_be(f3, int'(a[1:0])), m_wlane(f3, wd));
            end
         end
         n_vec++;
         if (ld_data !== ld_model) begin n_fail++; $display("FAIL rand_ld[%0d]: got %h want %h", k, ld_data, ld_model); end
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      mem_start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h40;
      @(negedge clk);
      mem_start = 0; bus_gnt = 1;
      @(negedge clk);
      bus_gnt = 0; rst = 0;
      #1;
      n_vec++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_rsp: stall got %b want 1", stall); end
      @(negedge clk);
      rst = 1;
      #1;
      n_vec++; if ({stall, done, bus_err_o, bus_req, misalign, ld_data} !== 37'b0) begin n_fail++;
         $display("FAIL rstmid_idle: got stall=%b done=%b err=%b req=%b mis=%b ld=%h want all 0", stall, done, bus_err_o, bus_req, misalign, ld_data); end
      bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus_rvalid = 0;
      #1;
      n_vec++; if ({stall, done, bus_err_o, ld_data} !== 35'b0) begin n_fail++;
         $display("FAIL rstmid_late_rvalid: got stall=%b done=%b err=%b ld=%h want all 0", stall, done, bus_err_o, ld_data); end
      ld_model = 0;
   endtask

   task automatic test_timeout;
      do_op(0, 3'b010, 32'h20, 32'h0, 32'h0, 0, 1000, 0);
      n_vec++; if ({o_err, o_done, o_req, o_hang} !== {32'd1, 32'd0, TO, 1'b0}) begin n_fail++;
         $display("FAIL timeout: got err=%0d done=%0d req=%0d hang=%0d want 1 0 %0d 0", o_err, o_done, o_req, o_hang, TO); end
      n_vec++; if ({bus_req, stall} !== 2'b00) begin n_fail++; $display("FAIL timeout_idle: got req=%b stall=%b want 00", bus_req, stall); end
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_misalign();
      test_err_stall();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef LSU_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
